// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline front end and the hazard controller.
// The controller takes the slave side; the pipeline (or a bench) takes the master side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rs_addr;
    logic [2:0]       id_rt_addr;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             ex_wr_en;
    logic             ex_wb_mem_select;
    logic [2:0]       ex_write_addr;
    logic             branch_taken;
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             ctrl_regs_sel;
    logic             flushing;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               ex_wr_en, ex_wb_mem_select, ex_write_addr, branch_taken,
        input  pc_write_en, if_id_write_en, if_id_flush, ctrl_regs_sel,
               flushing, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               ex_wr_en, ex_wb_mem_select, ex_write_addr, branch_taken,
        output pc_write_en, if_id_write_en, if_id_flush, ctrl_regs_sel,
               flushing, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch squash controller with saturating stall/flush counters.
// Control outputs are Mealy so the ID/EX bubble is injected in the detection cycle.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int R0_IS_ZERO   = 1,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] REM_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state, state_next;
    logic [3:0]       remaining, remaining_next;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             rs_hit, rt_hit, luh;
    logic             stall_evt, flush_evt;

    always_comb begin
        rs_hit = bus.id_rs_used && (bus.id_rs_addr == bus.ex_write_addr);
        rt_hit = bus.id_rt_used && (bus.id_rt_addr == bus.ex_write_addr);
        luh    = bus.ex_wr_en && bus.ex_wb_mem_select && (rs_hit || rt_hit);
        if ((R0_IS_ZERO != 0) && (bus.ex_write_addr == 3'd0)) begin
            luh = 1'b0;
        end
    end

    // NOTE: every output is given a default first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_next         = state;
        remaining_next     = remaining;
        bus.pc_write_en    = 1'b1;
        bus.if_id_write_en = 1'b1;
        bus.if_id_flush    = 1'b0;
        bus.ctrl_regs_sel  = 1'b0;
        stall_evt          = 1'b0;
        flush_evt          = 1'b0;

        case (state)
            RUN: begin
                // A taken branch makes the ID instruction wrong-path, so it beats the stall.
                if (bus.branch_taken) begin
                    bus.if_id_flush   = 1'b1;
                    bus.ctrl_regs_sel = 1'b1;
                    flush_evt         = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next     = FLUSH;
                        remaining_next = REM_INIT;
                    end
                end else if (luh) begin
                    bus.pc_write_en    = 1'b0;
                    bus.if_id_write_en = 1'b0;
                    bus.ctrl_regs_sel  = 1'b1;
                    stall_evt          = 1'b1;
                end
            end
            FLUSH: begin
                bus.if_id_flush   = 1'b1;
                bus.ctrl_regs_sel = 1'b1;
                flush_evt         = 1'b1;
                if (remaining == 4'd1) begin
                    state_next     = RUN;
                    remaining_next = 4'd0;
                end else begin
                    remaining_next = remaining - 4'd1;
                end
            end
            default: begin
                state_next     = RUN;
                remaining_next = 4'd0;
            end
        endcase

        if (rst) begin
            bus.pc_write_en    = 1'b1;
            bus.if_id_write_en = 1'b1;
            bus.if_id_flush    = 1'b0;
            bus.ctrl_regs_sel  = 1'b0;
            stall_evt          = 1'b0;
            flush_evt          = 1'b0;
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            remaining <= 4'd0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            if (stall_evt && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_evt && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.flushing  = (state == FLUSH) && !rst;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule
